// File: rtl/mest_log_pkg.sv
// Shared types and defaults for the processor result logger.
package mest_log_pkg;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOGGING  = 2'd1,
    DRAINING = 2'd2,
    DONE     = 2'd3
  } state_t;

  typedef struct packed {
    logic                  carry;
    logic                  zero;
    logic [DEF_DATA_W-1:0] result;
  } entry_t;

endpackage

// File: rtl/mest_log_fifo.sv
// First-word fall-through FIFO holding logged entries; storage is not reset.
module mest_log_fifo
  import mest_log_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_DATA_W + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wptr] <= wdata;
  end

  // Head is forced to zero when empty so the output reads zero out of reset.
  assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/mest_result_logger.sv
// Captures qualified processor results into a FIFO and drains them downstream after program end.
module mest_result_logger
  import mest_log_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic                      i_memory_reset,
  input  logic [DATA_W-1:0]         i_result,
  input  logic                      i_valid_result,
  input  logic                      i_carry,
  input  logic                      i_zero_flag,
  input  logic                      i_all_done,
  output logic [DATA_W+1:0]         o_out_data,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [$clog2(DEPTH):0]    o_level,
  output logic                      o_overflow,
  output logic [7:0]                o_drop_count,
  output logic                      o_drained
);

  state_t state;
  state_t state_next;
  logic   full;
  logic   empty;
  logic   push_req;
  logic   pop;
  logic   drop;

  assign push_req = i_valid_result && (state == LOGGING);
  assign pop      = o_out_valid && i_out_ready;
  assign drop     = push_req && full && !pop;

  mest_log_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 2)
  ) u_fifo (
    .clk   (clk),
    .rst   (i_reset),
    .clr   (i_memory_reset),
    .push  (push_req),
    .pop   (pop),
    .wdata ({i_carry, i_zero_flag, i_result}),
    .rdata (o_out_data),
    .level (o_level),
    .full  (full),
    .empty (empty)
  );

  assign o_out_valid = !empty;
  assign o_drained   = (state == DONE);

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (i_memory_reset) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     if (i_start)    state_next = LOGGING;
        LOGGING:  if (i_all_done) state_next = DRAINING;
        // Registered level: DONE follows one cycle after the last pop.
        DRAINING: if (empty)      state_next = DONE;
        DONE:     if (i_start)    state_next = LOGGING;
        default:                  state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else if (i_memory_reset) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else if (drop) begin
      o_overflow <= 1'b1;
      if (o_drop_count != 8'hFF) o_drop_count <= o_drop_count + 8'd1;
    end
  end

endmodule
